// File: rtl/sa_cache_mem_ctrl.sv
// sa_cache_mem_ctrl: line-granular backing memory for the sa_cache miss/writeback path.
// It takes one read (fill) or write (writeback) at a time and applies a fixed access
// latency. Completion is signalled by a one-cycle response pulse, and read data is held
// on o_memory_line.
module sa_cache_mem_ctrl #(
  parameter int LINE_ADDR_W = 8,
  parameter int LINE_W      = 128,
  parameter int MEM_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic                   i_req_rw,
  input  logic [LINE_ADDR_W-1:0] i_req_addr,
  input  logic [LINE_W-1:0]      i_req_line,
  output logic [LINE_W-1:0]      o_memory_line,
  output logic                   o_memory_response,
  output logic                   o_busy,
  output logic [CNT_W-1:0]       o_rd_count,
  output logic [CNT_W-1:0]       o_wr_count
);

  localparam int         DEPTH    = 1 << LINE_ADDR_W;
  localparam logic [7:0] LAT_LOAD = 8'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   rw_q, rw_d;
  logic [LINE_ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0]      line_q, line_d;

  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   resp_q, resp_d;
  logic [LINE_W-1:0]      mem_line_q, mem_line_d;
  logic [CNT_W-1:0]       rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]       wr_cnt_q, wr_cnt_d;

  logic                   enter_resp_s;
  logic                   op_rw_s;
  logic [LINE_ADDR_W-1:0] op_addr_s;
  logic [LINE_W-1:0]      op_line_s;
  logic                   mem_we_s;

  // Storage is cleared only at time 0; rst deliberately leaves the contents alone.
  logic [LINE_W-1:0]      mem_q [DEPTH] = '{default: '0};

  // Next-state logic: request capture, latency countdown and detection of the RESP entry edge.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    line_d       = line_q;
    enter_resp_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          rw_d   = i_req_rw;
          addr_d = i_req_addr;
          line_d = i_req_line;
          cnt_d  = LAT_LOAD;
          if (MEM_LATENCY == 1) begin
            state_d      = ST_RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_d = ST_BUSY;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d      = ST_RESP;
          enter_resp_s = 1'b1;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The memory operation uses the live request when the access completes straight from IDLE.
  always_comb begin
    if (state_q == ST_IDLE) begin
      op_rw_s   = i_req_rw;
      op_addr_s = i_req_addr;
      op_line_s = i_req_line;
    end else begin
      op_rw_s   = rw_q;
      op_addr_s = addr_q;
      op_line_s = line_q;
    end
    mem_we_s = enter_resp_s & op_rw_s & ~rst;
  end

  // Registered-output next values: handshake flags, read data capture, saturating statistics.
  always_comb begin
    ready_d    = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
    resp_d     = enter_resp_s;
    mem_line_d = mem_line_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    if (enter_resp_s) begin
      if (op_rw_s) begin
        if (wr_cnt_q != {CNT_W{1'b1}}) begin
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end else begin
          wr_cnt_d = wr_cnt_q;
        end
      end else begin
        mem_line_d = mem_q[op_addr_s];
        if (rd_cnt_q != {CNT_W{1'b1}}) begin
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end else begin
          rd_cnt_d = rd_cnt_q;
        end
      end
    end else begin
      mem_line_d = mem_line_q;
    end
  end

  // Control state and registered outputs; a reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      line_q     <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      resp_q     <= 1'b0;
      mem_line_q <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      line_q     <= line_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      resp_q     <= resp_d;
      mem_line_q <= mem_line_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  // Line storage: a writeback commits on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[op_addr_s] <= op_line_s;
    end
  end

  assign o_req_ready       = ready_q;
  assign o_busy            = busy_q;
  assign o_memory_response = resp_q;
  assign o_memory_line     = mem_line_q;
  assign o_rd_count        = rd_cnt_q;
  assign o_wr_count        = wr_cnt_q;

endmodule
